router_reg: RTL and testbench

ROUTER_REG -- requirements
Module: router_reg

---
 rtl/router_reg.sv | 183 ++++++++++++++++++
 tb/tb_router_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/router_reg.sv
//------------------------------------------------------------------------------
// router_reg
//   Datapath register block of a packet router. Captures the header byte,
//   steers header/payload/parity bytes to the output FIFO, parks a byte while
//   the FIFO is full, accumulates internal parity and flags parity errors.
//   Control comes from one-hot state decodes supplied by router_fsm.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module router_reg (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       fifo_full,
  input  logic       detect_add,
  input  logic       lfd_state,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  input  logic       rst_int_reg,
  output logic [7:0] dout,
  output logic       parity_done,
  output logic       low_pkt_valid,
  output logic       err
);

  // Destination address that no output port decodes; such headers are dropped.
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Registered state and next-state values
  logic [7:0] dout_q,          dout_d;
  logic [7:0] hdr_byte_q,      hdr_byte_d;
  logic [7:0] hold_byte_q,     hold_byte_d;
  logic [7:0] int_parity_q,    int_parity_d;
  logic [7:0] pkt_parity_q,    pkt_parity_d;
  logic       parity_done_q,   parity_done_d;
  logic       low_pkt_valid_q, low_pkt_valid_d;
  logic       err_q,           err_d;

  // While the FSM waits on a full FIFO every register simply holds, so all
  // decodes are qualified by the absence of full_state.
  logic w_upd_en;
  logic w_da;
  logic w_lfd;
  logic w_ld;
  logic w_laf;
  logic w_rst_int;

  assign w_upd_en  = ~full_state;
  assign w_da      = detect_add  & w_upd_en;
  assign w_lfd     = lfd_state   & w_upd_en;
  assign w_ld      = ld_state    & w_upd_en;
  assign w_laf     = laf_state   & w_upd_en;
  assign w_rst_int = rst_int_reg & w_upd_en;

  // Derived load events
  logic w_hdr_cap;     // valid header present on data_in
  logic w_ld_take;     // byte goes straight to the FIFO
  logic w_ld_park;     // byte must wait in hold_byte
  logic w_ld_parity;   // parity byte taken directly from data_in
  logic w_laf_parity;  // parity byte recovered from hold_byte
  logic w_pkt_end;     // pkt_valid observed low while loading

  assign w_hdr_cap    = w_da & pkt_valid & (data_in[1:0] != ADDR_INVALID);
  assign w_ld_take    = w_ld & ~fifo_full;
  assign w_ld_park    = w_ld & fifo_full;
  assign w_ld_parity  = w_ld & ~pkt_valid & ~fifo_full;
  assign w_laf_parity = w_laf & low_pkt_valid_q & ~parity_done_q;
  assign w_pkt_end    = w_ld & ~pkt_valid;

  // Header capture register
  always_comb begin
    hdr_byte_d = hdr_byte_q;
    if (w_hdr_cap) begin
      hdr_byte_d = data_in;
    end
  end

  // Output byte mux: header, live byte, or the parked byte after a full stall
  always_comb begin
    dout_d = dout_q;
    if (w_lfd) begin
      dout_d = hdr_byte_q;
    end else if (w_ld_take) begin
      dout_d = data_in;
    end else if (w_laf) begin
      dout_d = hold_byte_q;
    end
  end

  // Park the incoming byte when the FIFO cannot accept it
  always_comb begin
    hold_byte_d = hold_byte_q;
    if (w_ld_park) begin
      hold_byte_d = data_in;
    end
  end

  // Running parity over header and payload; the parity byte itself is excluded
  always_comb begin
    int_parity_d = int_parity_q;
    if (w_da) begin
      int_parity_d = 8'h00;
    end else if (w_lfd) begin
      int_parity_d = int_parity_q ^ hdr_byte_q;
    end else if (w_ld & pkt_valid) begin
      int_parity_d = int_parity_q ^ data_in;
    end
  end

  // Received parity byte, from data_in or from hold_byte after a stall
  always_comb begin
    pkt_parity_d = pkt_parity_q;
    if (w_ld_parity) begin
      pkt_parity_d = data_in;
    end else if (w_laf_parity) begin
      pkt_parity_d = hold_byte_q;
    end
  end

  // Parity-taken flag; survives until the next header phase
  always_comb begin
    parity_done_d = parity_done_q;
    if (w_ld_parity | w_laf_parity) begin
      parity_done_d = 1'b1;
    end else if (w_da) begin
      parity_done_d = 1'b0;
    end
  end

  // End-of-packet flag; setting takes precedence over the clear
  always_comb begin
    low_pkt_valid_d = low_pkt_valid_q;
    if (w_pkt_end) begin
      low_pkt_valid_d = 1'b1;
    end else if (w_rst_int) begin
      low_pkt_valid_d = 1'b0;
    end
  end

  // Parity error: evaluated once per packet, cleared by the next valid header phase
  always_comb begin
    err_d = err_q;
    if (w_rst_int) begin
      err_d = (int_parity_q != pkt_parity_q);
    end else if (w_da & pkt_valid) begin
      err_d = 1'b0;
    end
  end

  // State register with asynchronous clear; partial parity is discarded on reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout_q          <= 8'h00;
      hdr_byte_q      <= 8'h00;
      hold_byte_q     <= 8'h00;
      int_parity_q    <= 8'h00;
      pkt_parity_q    <= 8'h00;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      dout_q          <= dout_d;
      hdr_byte_q      <= hdr_byte_d;
      hold_byte_q     <= hold_byte_d;
      int_parity_q    <= int_parity_d;
      pkt_parity_q    <= pkt_parity_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
    end
  end

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_router_reg.sv
//------------------------------------------------------------------------------
// tb_router_reg
//   Directed self-checking bench for router_reg.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_router_reg;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [7:0] dout;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;

  int n_cmp;
  int n_err;

  // FSM decode codes used by the stimulus
  localparam int S_IDLE = 0;
  localparam int S_DA   = 1;
  localparam int S_LFD  = 2;
  localparam int S_LD   = 3;
  localparam int S_LAF  = 4;
  localparam int S_FULL = 5;
  localparam int S_RST  = 6;

  router_reg dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .dout          (dout),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of decodes/inputs, clock it, then sample 1 time unit later.
  task automatic cyc(input int st, input logic pv, input logic [7:0] d, input logic ff);
    pkt_valid   = pv;
    data_in     = d;
    fifo_full   = ff;
    detect_add  = (st == S_DA);
    lfd_state   = (st == S_LFD);
    ld_state    = (st == S_LD);
    laf_state   = (st == S_LAF);
    full_state  = (st == S_FULL);
    rst_int_reg = (st == S_RST);
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn = 1'b0;
    pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 1'b0;
    detect_add = 1'b0; lfd_state = 1'b0; ld_state = 1'b0;
    laf_state = 1'b0; full_state = 1'b0; rst_int_reg = 1'b0;

    // Reset state
    @(posedge clock); #1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_flags", {5'd0, parity_done, low_pkt_valid, err}, 8'h00);
    #3 resetn = 1'b1;

    // Good packet 05 / A3 / A6
    cyc(S_DA,  1'b1, 8'h05, 1'b0);
    chk("good_da_dout", dout, 8'h00);
    cyc(S_LFD, 1'b1, 8'hA3, 1'b0);
    chk("good_hdr_out", dout, 8'h05);
    cyc(S_LD,  1'b1, 8'hA3, 1'b0);
    chk("good_payload", dout, 8'hA3);
    cyc(S_LD,  1'b0, 8'hA6, 1'b0);
    chk("good_parity_out", dout, 8'hA6);
    chk("good_pdone", {7'd0, parity_done}, 8'h01);
    chk("good_lpv_set", {7'd0, low_pkt_valid}, 8'h01);
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    chk("good_err", {7'd0, err}, 8'h00);
    chk("good_lpv_clr", {7'd0, low_pkt_valid}, 8'h00);
    chk("good_pdone_held", {7'd0, parity_done}, 8'h01);

    // Bad parity: same packet with parity 00
    cyc(S_DA,  1'b1, 8'h05, 1'b0);
    chk("bad_pdone_clr", {7'd0, parity_done}, 8'h00);
    cyc(S_LFD, 1'b1, 8'hA3, 1'b0);
    cyc(S_LD,  1'b1, 8'hA3, 1'b0);
    cyc(S_LD,  1'b0, 8'h00, 1'b0);
    chk("bad_parity_out", dout, 8'h00);
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    chk("bad_err_set", {7'd0, err}, 8'h01);
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    chk("bad_err_held_idle", {7'd0, err}, 8'h01);
    cyc(S_DA,  1'b0, 8'h05, 1'b0);
    chk("bad_err_held_nopv", {7'd0, err}, 8'h01);
    cyc(S_DA,  1'b1, 8'h05, 1'b0);
    chk("bad_err_clr", {7'd0, err}, 8'h00);

    // Full during payload: 3C parked, then released in laf; parity 05^3C = 39
    cyc(S_LFD, 1'b1, 8'h3C, 1'b0);
    chk("full_hdr_out", dout, 8'h05);
    cyc(S_LD,  1'b1, 8'h3C, 1'b1);
    chk("full_dout_held", dout, 8'h05);
    cyc(S_FULL, 1'b1, 8'h3C, 1'b1);
    chk("full_wait_dout", dout, 8'h05);
    cyc(S_LAF, 1'b1, 8'h3C, 1'b0);
    chk("full_laf_dout", dout, 8'h3C);
    chk("full_laf_pdone", {7'd0, parity_done}, 8'h00);
    cyc(S_LD,  1'b0, 8'h39, 1'b0);
    chk("full_parity_out", dout, 8'h39);
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    chk("full_err", {7'd0, err}, 8'h00);

    // Full on the parity byte
    cyc(S_DA,  1'b1, 8'h05, 1'b0);
    cyc(S_LFD, 1'b1, 8'hA3, 1'b0);
    cyc(S_LD,  1'b1, 8'hA3, 1'b0);
    cyc(S_LD,  1'b0, 8'hA6, 1'b1);
    chk("pfull_dout_held", dout, 8'hA3);
    chk("pfull_lpv", {7'd0, low_pkt_valid}, 8'h01);
    chk("pfull_pdone0", {7'd0, parity_done}, 8'h00);
    cyc(S_FULL, 1'b0, 8'h00, 1'b1);
    cyc(S_LAF, 1'b0, 8'h00, 1'b0);
    chk("pfull_laf_dout", dout, 8'hA6);
    chk("pfull_pdone1", {7'd0, parity_done}, 8'h01);
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    chk("pfull_lpv_clr", {7'd0, low_pkt_valid}, 8'h00);
    chk("pfull_err", {7'd0, err}, 8'h00);

    // Invalid address 07: header register keeps 05
    cyc(S_DA,  1'b1, 8'h07, 1'b0);
    cyc(S_LFD, 1'b1, 8'h00, 1'b0);
    chk("inv_addr_hdr", dout, 8'h05);

    // Asynchronous reset mid-payload
    cyc(S_DA,  1'b1, 8'h09, 1'b0);
    cyc(S_LFD, 1'b1, 8'h5A, 1'b0);
    chk("ar_hdr_out", dout, 8'h09);
    cyc(S_LD,  1'b1, 8'h5A, 1'b0);
    chk("ar_payload", dout, 8'h5A);
    #2 resetn = 1'b0;
    #1;
    chk("ar_dout_clr", dout, 8'h00);
    chk("ar_flags_clr", {5'd0, parity_done, low_pkt_valid, err}, 8'h00);
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    #3 resetn = 1'b1;

    // Good packet after reset: stale partial parity must not leak in
    cyc(S_DA,  1'b1, 8'h05, 1'b0);
    cyc(S_LFD, 1'b1, 8'hA3, 1'b0);
    chk("post_hdr_out", dout, 8'h05);
    cyc(S_LD,  1'b1, 8'hA3, 1'b0);
    cyc(S_LD,  1'b0, 8'hA6, 1'b0);
    chk("post_parity_out", dout, 8'hA6);
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    chk("post_err", {7'd0, err}, 8'h00);
    chk("post_pdone", {7'd0, parity_done}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
